// File: rtl/led_rgb_pkg.sv
//==============================================================================
// Module   : led_rgb_pkg
// Purpose  : Shared types and constants for the RGB LED blink core.
//            - chan_state_e : per-colour channel state
//            - c_dur_width_dflt : default width of duration inputs/counters
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package led_rgb_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_STEADY = 2'd2,
    ST_BLINK  = 2'd3
  } chan_state_e;

  localparam int c_dur_width_dflt = 32;

endpackage

`default_nettype wire

// File: rtl/led_rgb_blink_core_if.sv
//==============================================================================
// Module   : led_rgb_blink_core_if
// Purpose  : Control/status bundle between the LED register block and the
//            RGB blink core.
//            Control (register block -> core): mode_*, enable_*, holded_*,
//            duration_*.  Status/pins (core -> outside): led_*_o, led_*_sts.
//            master : register-block side, drives control, reads status
//            slave  : blink-core side
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface led_rgb_blink_core_if
  import led_rgb_pkg::*;
#(
  parameter int DUR_WIDTH = c_dur_width_dflt
);

  logic                 mode_r,     mode_g,     mode_b;
  logic                 enable_r,   enable_g,   enable_b;
  logic                 holded_r,   holded_g,   holded_b;
  logic [DUR_WIDTH-1:0] duration_r, duration_g, duration_b;
  logic                 led_r_o,    led_g_o,    led_b_o;
  logic                 led_r_sts,  led_g_sts,  led_b_sts;

  modport master (
    output mode_r, mode_g, mode_b,
    output enable_r, enable_g, enable_b,
    output holded_r, holded_g, holded_b,
    output duration_r, duration_g, duration_b,
    input  led_r_o, led_g_o, led_b_o,
    input  led_r_sts, led_g_sts, led_b_sts
  );

  modport slave (
    input  mode_r, mode_g, mode_b,
    input  enable_r, enable_g, enable_b,
    input  holded_r, holded_g, holded_b,
    input  duration_r, duration_g, duration_b,
    output led_r_o, led_g_o, led_b_o,
    output led_r_sts, led_g_sts, led_b_sts
  );

endinterface

`default_nettype wire

// File: rtl/led_blink_channel.sv
//==============================================================================
// Module   : led_blink_channel
// Purpose  : One colour channel: OFF / HOLD / STEADY / BLINK with a
//            programmable half-period.
// Ports    : aclk, aresetn (async, active-low), soft_rst (sync, active-high),
//            mode, enable, holded, duration[DUR_WIDTH] -> led (registered,
//            logical state, 1 = lit)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module led_blink_channel
  import led_rgb_pkg::*;
#(
  parameter int DUR_WIDTH = c_dur_width_dflt
) (
  input  wire logic                 aclk,
  input  wire logic                 aresetn,
  input  wire logic                 soft_rst,
  input  wire logic                 mode,
  input  wire logic                 enable,
  input  wire logic                 holded,
  input  wire logic [DUR_WIDTH-1:0] duration,
  output logic                      led
);

  localparam logic [DUR_WIDTH-1:0] c_one = {{(DUR_WIDTH-1){1'b0}}, 1'b1};

  chan_state_e          r_state;
  chan_state_e          w_state_nxt;
  logic                 r_led;
  logic                 w_led_nxt;
  logic [DUR_WIDTH-1:0] r_cnt;
  logic [DUR_WIDTH-1:0] w_cnt_nxt;
  logic [DUR_WIDTH-1:0] w_cnt_cur;
  logic [DUR_WIDTH-1:0] w_eff_m1;

  // eff = max(duration, 1); eff-1 therefore never underflows.
  assign w_eff_m1 = (duration == '0) ? '0 : (duration - c_one);

  // The count only carries meaning while already blinking; any other state
  // leaves it at zero, so a fresh BLINK always starts from zero.
  assign w_cnt_cur = (r_state == ST_BLINK) ? r_cnt : '0;

  // State register (also holds the LED bit and the half-period counter).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_OFF;
      r_led   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state is decided purely by the current inputs; soft reset wins.
  always_comb begin
    w_state_nxt = ST_OFF;
    if (soft_rst) begin
      w_state_nxt = ST_OFF;
    end else if (!enable) begin
      w_state_nxt = holded ? ST_HOLD : ST_OFF;
    end else begin
      w_state_nxt = mode ? ST_BLINK : ST_STEADY;
    end
  end

  // Outputs follow the rule of the state being entered on this edge, so an
  // enable drop coincident with a due toggle freezes the pre-toggle value.
  always_comb begin
    w_led_nxt = 1'b0;
    w_cnt_nxt = '0;
    case (w_state_nxt)
      ST_OFF: begin
        w_led_nxt = 1'b0;
        w_cnt_nxt = '0;
      end
      ST_HOLD: begin
        w_led_nxt = r_led;
        w_cnt_nxt = '0;
      end
      ST_STEADY: begin
        w_led_nxt = 1'b1;
        w_cnt_nxt = '0;
      end
      ST_BLINK: begin
        // >= rather than == so a shrunk duration toggles at once.
        if (w_cnt_cur >= w_eff_m1) begin
          w_led_nxt = ~r_led;
          w_cnt_nxt = '0;
        end else begin
          w_led_nxt = r_led;
          w_cnt_nxt = w_cnt_cur + c_one;
        end
      end
      default: begin
        w_led_nxt = 1'b0;
        w_cnt_nxt = '0;
      end
    endcase
  end

  assign led = r_led;

endmodule

`default_nettype wire

// File: rtl/led_rgb_blink_core.sv
//==============================================================================
// Module   : led_rgb_blink_core
// Purpose  : Drives the three pins of an RGB LED from the register block's
//            control outputs; returns the logical LED state for readback.
// Ports    : aclk, aresetn (async, active-low), user_resetn (sync soft reset,
//            active-low), ctrl (led_rgb_blink_core_if.slave: mode/enable/
//            holded/duration per colour in, led_*_o pins and led_*_sts out)
// Params   : LED_ACTIVE_LOW - inverts the pins only; DUR_WIDTH - duration width
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module led_rgb_blink_core
  import led_rgb_pkg::*;
#(
  parameter int LED_ACTIVE_LOW = 0,
  parameter int DUR_WIDTH      = c_dur_width_dflt
) (
  input  wire logic           aclk,
  input  wire logic           aresetn,
  input  wire logic           user_resetn,
  led_rgb_blink_core_if.slave ctrl
);

  localparam logic c_pin_inv = (LED_ACTIVE_LOW != 0);

  logic                 w_soft_rst;
  logic [2:0]           w_mode;
  logic [2:0]           w_enable;
  logic [2:0]           w_holded;
  logic [DUR_WIDTH-1:0] w_duration [3];
  logic [2:0]           w_led;

  assign w_soft_rst    = ~user_resetn;
  assign w_mode        = {ctrl.mode_b,   ctrl.mode_g,   ctrl.mode_r};
  assign w_enable      = {ctrl.enable_b, ctrl.enable_g, ctrl.enable_r};
  assign w_holded      = {ctrl.holded_b, ctrl.holded_g, ctrl.holded_r};
  assign w_duration[0] = ctrl.duration_r;
  assign w_duration[1] = ctrl.duration_g;
  assign w_duration[2] = ctrl.duration_b;

  // Index 0 = red, 1 = green, 2 = blue.
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    led_blink_channel #(
      .DUR_WIDTH (DUR_WIDTH)
    ) u_ch (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .soft_rst (w_soft_rst),
      .mode     (w_mode[gi]),
      .enable   (w_enable[gi]),
      .holded   (w_holded[gi]),
      .duration (w_duration[gi]),
      .led      (w_led[gi])
    );
  end

  assign ctrl.led_r_sts = w_led[0];
  assign ctrl.led_g_sts = w_led[1];
  assign ctrl.led_b_sts = w_led[2];

  // Pins are combinational from the registers: no extra latency.
  assign ctrl.led_r_o = w_led[0] ^ c_pin_inv;
  assign ctrl.led_g_o = w_led[1] ^ c_pin_inv;
  assign ctrl.led_b_o = w_led[2] ^ c_pin_inv;

endmodule

`default_nettype wire

// File: tb/tb_led_rgb_blink_core.sv
//==============================================================================
// Module   : tb_led_rgb_blink_core
// Purpose  : Self-checking bench for led_rgb_blink_core. Two cores (active-high
//            and active-low pins) share one stimulus; a reference model pushes
//            the expected logical LED state per edge into a scoreboard queue
//            that a separate monitor pops and compares.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_led_rgb_blink_core;
  import led_rgb_pkg::*;

  localparam int DW = 32;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic user_resetn = 1'b1;
  always #5 aclk = ~aclk;

  // Stimulus, index 0 = red, 1 = green, 2 = blue.
  logic [2:0]    en = '0, md = '0, hd = '0;
  logic [DW-1:0] dur [3];

  led_rgb_blink_core_if #(.DUR_WIDTH(DW)) if_ah ();
  led_rgb_blink_core_if #(.DUR_WIDTH(DW)) if_al ();

  assign if_ah.mode_r = md[0];   assign if_al.mode_r = md[0];
  assign if_ah.mode_g = md[1];   assign if_al.mode_g = md[1];
  assign if_ah.mode_b = md[2];   assign if_al.mode_b = md[2];
  assign if_ah.enable_r = en[0]; assign if_al.enable_r = en[0];
  assign if_ah.enable_g = en[1]; assign if_al.enable_g = en[1];
  assign if_ah.enable_b = en[2]; assign if_al.enable_b = en[2];
  assign if_ah.holded_r = hd[0]; assign if_al.holded_r = hd[0];
  assign if_ah.holded_g = hd[1]; assign if_al.holded_g = hd[1];
  assign if_ah.holded_b = hd[2]; assign if_al.holded_b = hd[2];
  assign if_ah.duration_r = dur[0]; assign if_al.duration_r = dur[0];
  assign if_ah.duration_g = dur[1]; assign if_al.duration_g = dur[1];
  assign if_ah.duration_b = dur[2]; assign if_al.duration_b = dur[2];

  led_rgb_blink_core #(.LED_ACTIVE_LOW(0), .DUR_WIDTH(DW)) u_dut_ah (
    .aclk (aclk), .aresetn (aresetn), .user_resetn (user_resetn), .ctrl (if_ah.slave)
  );
  led_rgb_blink_core #(.LED_ACTIVE_LOW(1), .DUR_WIDTH(DW)) u_dut_al (
    .aclk (aclk), .aresetn (aresetn), .user_resetn (user_resetn), .ctrl (if_al.slave)
  );

  logic [2:0] sts_ah, sts_al, pin_ah, pin_al;
  assign sts_ah = {if_ah.led_b_sts, if_ah.led_g_sts, if_ah.led_r_sts};
  assign sts_al = {if_al.led_b_sts, if_al.led_g_sts, if_al.led_r_sts};
  assign pin_ah = {if_ah.led_b_o, if_ah.led_g_o, if_ah.led_r_o};
  assign pin_al = {if_al.led_b_o, if_al.led_g_o, if_al.led_r_o};

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Per colour: the lit state and how many blink edges have elapsed since the
  // last toggle (or since blinking began). A toggle is due once eff edges
  // have elapsed, eff being the duration with zero treated as one.
  bit     m_led [3];
  longint m_since [3];
  logic [2:0] sb_q [$];

  function automatic void model_step();
    for (int c = 0; c < 3; c++) begin
      longint eff;
      eff = (dur[c] == 0) ? 1 : longint'(dur[c]);
      if (!aresetn || !user_resetn) begin
        m_led[c] = 1'b0; m_since[c] = 0;
      end else if (!en[c]) begin
        if (!hd[c]) m_led[c] = 1'b0;
        m_since[c] = 0;
      end else if (!md[c]) begin
        m_led[c] = 1'b1; m_since[c] = 0;
      end else if (m_since[c] + 1 >= eff) begin
        m_led[c] = ~m_led[c]; m_since[c] = 0;
      end else begin
        m_since[c] = m_since[c] + 1;
      end
    end
  endfunction

  // Called at a falling edge once inputs are set: predict the next rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      sb_q.push_back({m_led[2], m_led[1], m_led[0]});
      @(negedge aclk);
    end
  endtask

  // -------------------------------------------------------------- monitor
  always @(posedge aclk) begin
    #1;
    if (sb_q.size() != 0) begin
      logic [2:0] e;
      e = sb_q.pop_front();
      check("sts_active_high", sts_ah, e);
      check("sts_active_low",  sts_al, e);
      check("pin_active_high", pin_ah, e);
      check("pin_active_low",  pin_al, ~e);
    end
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    for (int c = 0; c < 3; c++) dur[c] = '0;
    @(negedge aclk);
    tick(2);                               // held in reset: all zero
    aresetn = 1'b1;
    tick(2);

    // Red blink, duration 4: toggle every 4 edges, 10+ periods.
    en[0] = 1'b1; md[0] = 1'b1; dur[0] = 32'd4;
    tick(85);

    // Asynchronous reset mid-blink: outputs clear without a clock edge.
    en[1] = 1'b1; md[1] = 1'b1; dur[1] = 32'd3;
    tick(7);
    @(posedge aclk); #3;
    aresetn = 1'b0;
    #1;
    check("async_rst_sts_ah", sts_ah, 3'b000);
    check("async_rst_sts_al", sts_al, 3'b000);
    check("async_rst_pin_ah", pin_ah, 3'b000);
    check("async_rst_pin_al", pin_al, 3'b111);
    for (int c = 0; c < 3; c++) begin m_led[c] = 1'b0; m_since[c] = 0; end
    @(negedge aclk);
    tick(2);
    aresetn = 1'b1;
    en = '0; md = '0;
    tick(2);

    // Duration shrink 100 -> 10 with 50 edges already counted.
    en[0] = 1'b1; md[0] = 1'b1; dur[0] = 32'd100;
    tick(50);
    dur[0] = 32'd10;
    tick(35);
    en[0] = 1'b0;

    // Hold vs off on green.
    for (int pass = 0; pass < 2; pass++) begin
      int guard;
      en[1] = 1'b1; md[1] = 1'b1; dur[1] = 32'd3; hd[1] = (pass == 0);
      guard = 0;
      tick(1);
      while (!m_led[1] && guard < 20) begin tick(1); guard++; end
      if (!m_led[1]) begin
        miscompares++;
        $display("FAIL hold_setup: green never lit, actual=0 required=1");
      end
      en[1] = 1'b0;
      tick(pass == 0 ? 50 : 5);
      hd[1] = 1'b0;
      tick(1);
    end

    // Edge durations on blue: 0 then 1 both toggle every edge.
    en[2] = 1'b1; md[2] = 1'b1; dur[2] = 32'd0;
    tick(6);
    dur[2] = 32'd1;
    tick(6);

    // Soft reset while all channels steady.
    en = 3'b111; md = 3'b000;
    tick(3);
    user_resetn = 1'b0;
    tick(1);
    user_resetn = 1'b1;
    tick(3);
    md = 3'b111; dur[0] = 32'd5; dur[1] = 32'd2; dur[2] = 32'd7;
    tick(6);
    user_resetn = 1'b0;
    tick(1);
    user_resetn = 1'b1;
    tick(20);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          en[c]  = ($urandom_range(0, 3) != 0);
          md[c]  = $urandom_range(0, 1) == 1;
          hd[c]  = $urandom_range(0, 1) == 1;
          dur[c] = DW'($urandom_range(0, 12));
        end
      end
      user_resetn = ($urandom_range(0, 59) != 0);
      tick(1);
    end
    user_resetn = 1'b1;

    repeat (3) @(negedge aclk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
